serial_add_arbiter: RTL and testbench
=====================================

Name: serial_add_arbiter

Overview:
- Sequences one shared 1-bit full-adder slice (two half adders plus an OR) to add WIDTH-bit operands serially, LSB first, one bit per clock.
- Shares that slice between two requesters using round-robin arbitration, with a req/gnt/done handshake.
- Sits between operand producers and the half-adder datapath cells, and trades adder area for latency.

Parameters:
- WIDTH, 8, operand/result width in bits; must be >= 2.
- CNT_W, 4, bit-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk, in, 1, rising-edge clock.
- rst_n, in, 1, asynchronous active-low reset.
- req0, in, 1, requester 0 wants an addition.
- a0, in, WIDTH, requester 0 operand A.
- b0, in, WIDTH, requester 0 operand B.
- req1, in, 1, requester 1 wants an addition.
- a1, in, WIDTH, requester 1 operand A.
- b1, in, WIDTH, requester 1 operand B.
- gnt0, out, 1, one-cycle acceptance of requester 0 (combinational in IDLE).
- gnt1, out, 1, one-cycle acceptance of requester 1 (combinational in IDLE).
- busy, out, 1, high in RUN and DONE.
- done, out, 1, one-cycle result-valid pulse.
- done_id, out, 1, which requester the result belongs to.
- sum, out, WIDTH, registered result.
- cout, out, 1, registered carry out.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - Shift registers, carry, bit counter, sum, cout, done and done_id clear to 0.
  - Priority pointer prio is set to 0, so requester 0 is preferred.
  - gnt0, gnt1 and busy are 0.
- FSM has three states: IDLE, RUN and DONE.
- IDLE:
  - If only one req is high, that requester is granted.
  - If both are high, the requester equal to prio is granted.
  - gnt is high in the same cycle; at most one gnt is high.
  - At the next edge:
    - the granted a/b are latched into shift registers sa/sb;
    - carry is cleared and cnt is set to 0;
    - the owner id is stored;
    - prio becomes the non-granted id;
    - state goes to RUN.
  - With no req, the block stays in IDLE and no state changes.
- RUN, at each edge:
  - s = sa[0]^sb[0]^c, and c <= (sa[0]&sb[0]) | (c&(sa[0]^sb[0])).
  - sa and sb shift right by 1.
  - s shifts into the MSB of an accumulator acc.
  - cnt increments.
  - When cnt == WIDTH-1 at the edge: sum <= the final acc value including the last bit, cout <= final carry, done_id <= owner, and state goes to DONE.
  - RUN therefore lasts exactly WIDTH cycles.
- DONE:
  - done = 1 for exactly one cycle.
  - The block returns to IDLE at the next edge.
- Latency: if gnt is high in cycle k, done is high in cycle k+WIDTH+1. Back-to-back throughput is one result per WIDTH+2 cycles.
- Result is modulo 2^WIDTH. cout equals bit WIDTH of the true sum a+b.
- sum, cout and done_id hold their values after done until the next done. They are not cleared in IDLE.
- Handshake rules:
  - A requester holds req and its operands stable until it sees gnt.
  - Operands are sampled only at the gnt edge. Later operand changes are ignored.
  - req may drop or stay high after gnt. If it stays high, it is a new request.
  - req during RUN or DONE is neither granted nor lost; it is served when IDLE returns, if still asserted.
- Fairness: with both reqs held continuously, grants alternate 0,1,0,1,...
- Reset mid-operation aborts the addition:
  - no done is produced;
  - sum and cout are 0;
  - prio returns to 0.
- No X propagation: busy = (state != IDLE), and all outputs are defined from reset.

Test Plan:
1. WIDTH=8, only req0 high, a0=8'h0F, b0=8'h01 → gnt0 pulse in cycle k; done in k+9; sum=8'h10, cout=0, done_id=0; busy high k+1..k+9.
2. Only req1 high, a1=8'hFF, b1=8'h01 → sum=8'h00, cout=1, done_id=1. Then a1=8'hA5, b1=8'h5A → sum=8'hFF, cout=0.
3. After reset, assert req0 and req1 in the same cycle (a0=3,b0=4; a1=8'h80,b1=8'h80) → gnt0 first with sum=8'h07, done_id=0. Then gnt1 in the IDLE cycle after that done, with sum=8'h00, cout=1, done_id=1.
4. Hold req0 and req1 high for 6 transactions → grant sequence 0,1,0,1,0,1. gnt0 and gnt1 are never high together. Spacing between dones is 10 cycles.
5. Start a0=8'hFF, b0=8'hFF, then drop rst_n for 1 cycle at RUN cycle 4 → no done pulse, sum=0, cout=0, busy=0. After release, req1 alone is granted and completes normally.
6. Raise req1 during requester 0's RUN → gnt1 stays low until IDLE. Change a0 after gnt0 → result still uses the latched a0.

Source files
------------

// File: rtl/serial_add_arbiter_if.sv
// Request/grant/result bundle between two operand producers and the shared
// bit-serial adder.
interface serial_add_arbiter_if #(
  parameter int WIDTH = 8
);
  logic             req0;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic             req1;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic             gnt0;
  logic             gnt1;
  logic             busy;
  logic             done;
  logic             done_id;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output req0, a0, b0, req1, a1, b1,
    input  gnt0, gnt1, busy, done, done_id, sum, cout
  );

  modport slave (
    input  req0, a0, b0, req1, a1, b1,
    output gnt0, gnt1, busy, done, done_id, sum, cout
  );
endinterface

// File: rtl/serial_add_arbiter.sv
// Bit-serial adder built around one full-adder slice, shared round-robin
// between two requesters; one result bit per clock, LSB first.
module serial_add_arbiter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_add_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [WIDTH-1:0]   sa_r;
  logic [WIDTH-1:0]   sb_r;
  logic [WIDTH-1:0]   acc_r;
  logic [WIDTH-1:0]   acc_nxt_s;
  logic               carry_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               owner_r;
  logic               prio_r;
  logic [WIDTH-1:0]   sum_r;
  logic               cout_r;
  logic               done_id_r;
  logic               any_req_s;
  logic               grant_id_s;
  logic               last_bit_s;
  logic [1:0]         fa_s;
  logic               gnt0_s;
  logic               gnt1_s;
  logic               busy_s;
  logic               done_s;

  // Two half adders plus an OR; returns {carry, sum}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    logic h1_sum;
    logic h1_cry;
    logic h2_sum;
    logic h2_cry;
    h1_sum = x ^ y;
    h1_cry = x & y;
    h2_sum = h1_sum ^ ci;
    h2_cry = h1_sum & ci;
    return {h1_cry | h2_cry, h2_sum};
  endfunction

  assign any_req_s  = bus.req0 | bus.req1;
  assign fa_s       = full_add(sa_r[0], sb_r[0], carry_r);
  assign acc_nxt_s  = {fa_s[0], acc_r[WIDTH-1:1]};
  assign last_bit_s = (cnt_r == CNT_W'(WIDTH - 1));

  // Round-robin pick: prio only breaks ties when both requesters are waiting.
  always_comb begin
    grant_id_s = 1'b0;
    if (bus.req0 && bus.req1) begin
      grant_id_s = prio_r;
    end else if (bus.req1) begin
      grant_id_s = 1'b1;
    end else begin
      grant_id_s = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (any_req_s) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_bit_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM outputs; grants are gated by rst_n so none can leak out during reset.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    busy_s = 1'b0;
    done_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (rst_n && any_req_s) begin
          gnt0_s = ~grant_id_s;
          gnt1_s = grant_id_s;
        end else begin
          gnt0_s = 1'b0;
          gnt1_s = 1'b0;
        end
      end
      ST_RUN: busy_s = 1'b1;
      ST_DONE: begin
        busy_s = 1'b1;
        done_s = 1'b1;
      end
      default: busy_s = 1'b0;
    endcase
  end

  // Operand capture, serial add datapath and held result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa_r      <= {WIDTH{1'b0}};
      sb_r      <= {WIDTH{1'b0}};
      acc_r     <= {WIDTH{1'b0}};
      carry_r   <= 1'b0;
      cnt_r     <= {CNT_W{1'b0}};
      owner_r   <= 1'b0;
      prio_r    <= 1'b0;
      sum_r     <= {WIDTH{1'b0}};
      cout_r    <= 1'b0;
      done_id_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (any_req_s) begin
            sa_r    <= grant_id_s ? bus.a1 : bus.a0;
            sb_r    <= grant_id_s ? bus.b1 : bus.b0;
            carry_r <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
            owner_r <= grant_id_s;
            prio_r  <= ~grant_id_s;
          end
        end
        ST_RUN: begin
          sa_r    <= sa_r >> 1;
          sb_r    <= sb_r >> 1;
          acc_r   <= acc_nxt_s;
          carry_r <= fa_s[1];
          cnt_r   <= cnt_r + CNT_W'(1);
          if (last_bit_s) begin
            sum_r     <= acc_nxt_s;
            cout_r    <= fa_s[1];
            done_id_r <= owner_r;
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  assign bus.gnt0    = gnt0_s;
  assign bus.gnt1    = gnt1_s;
  assign bus.busy    = busy_s;
  assign bus.done    = done_s;
  assign bus.done_id = done_id_r;
  assign bus.sum     = sum_r;
  assign bus.cout    = cout_r;

endmodule

// File: tb/tb_serial_add_arbiter.sv
// Directed bench for serial_add_arbiter: a cycle-level transaction model
// checks every output each cycle, and a literal table pins each result.
module tb_serial_add_arbiter;

  localparam int W        = 8;
  localparam int N_RESULT = 14;

  logic clk;
  logic rst_n;
  int   cyc;
  bit   tb_end;

  serial_add_arbiter_if #(.WIDTH(W)) bus ();

  serial_add_arbiter #(.WIDTH(W), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // {done_id, cout, sum} expected for the n-th completed addition
  logic [9:0] lit_exp [0:15];
  bit         lit_has [0:15];

  int n_tests;
  int n_fail;

  // Model state: cycle the adder is free again, pending result, held result
  int         m_free;
  int         m_done_cyc;
  bit         m_pend;
  bit         m_prio;
  logic [7:0] p_sum;
  logic       p_cout;
  logic       p_id;
  logic [7:0] m_sum;
  logic       m_cout;
  logic       m_id;
  int         m_ndone;
  int         dut_ndone;
  bit         exp_done;
  bit         exp_busy;
  bit         eg0;
  bit         eg1;
  bit         gid;
  logic [8:0] full;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (tb_end) begin
      chk("done_count", dut_ndone, N_RESULT);
      chk("model_done_count", m_ndone, N_RESULT);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
    end else if (!rst_n) begin
      chk("reset_outputs",
          {21'd0, bus.gnt1, bus.gnt0, bus.busy, bus.done, bus.done_id, bus.cout, bus.sum},
          32'd0);
      m_free  = 0;
      m_pend  = 1'b0;
      m_prio  = 1'b0;
      m_sum   = 8'h00;
      m_cout  = 1'b0;
      m_id    = 1'b0;
    end else begin
      exp_done = m_pend && (cyc == m_done_cyc);
      exp_busy = (cyc < m_free);
      if (exp_done) begin
        m_sum  = p_sum;
        m_cout = p_cout;
        m_id   = p_id;
        m_pend = 1'b0;
        if (lit_has[m_ndone]) begin
          chk("literal_result", {22'd0, bus.done_id, bus.cout, bus.sum}, {22'd0, lit_exp[m_ndone]});
        end
        m_ndone++;
      end
      eg0 = 1'b0;
      eg1 = 1'b0;
      if (!exp_busy && (bus.req0 || bus.req1)) begin
        gid  = (bus.req0 && bus.req1) ? m_prio : bus.req1;
        eg0  = ~gid;
        eg1  = gid;
        full = gid ? ({1'b0, bus.a1} + {1'b0, bus.b1}) : ({1'b0, bus.a0} + {1'b0, bus.b0});
        p_sum      = full[7:0];
        p_cout     = full[8];
        p_id       = gid;
        m_pend     = 1'b1;
        m_done_cyc = cyc + W + 1;
        m_free     = cyc + W + 2;
        m_prio     = ~gid;
      end
      if (bus.done) dut_ndone++;
      chk("gnt", {30'd0, bus.gnt1, bus.gnt0}, {30'd0, eg1, eg0});
      chk("busy", {31'd0, bus.busy}, {31'd0, exp_busy});
      chk("done", {31'd0, bus.done}, {31'd0, exp_done});
      chk("sum", {24'd0, bus.sum}, {24'd0, m_sum});
      chk("cout", {31'd0, bus.cout}, {31'd0, m_cout});
      chk("done_id", {31'd0, bus.done_id}, {31'd0, m_id});
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      lit_exp[i] = 10'h000;
      lit_has[i] = 1'b0;
    end
    lit_exp[0]  = 10'h010;  // 0F+01, id0
    lit_exp[1]  = 10'h300;  // FF+01, id1, carry
    lit_exp[2]  = 10'h2FF;  // A5+5A, id1
    lit_exp[3]  = 10'h007;  // 03+04, id0
    lit_exp[4]  = 10'h300;  // 80+80, id1, carry
    lit_exp[5]  = 10'h100;  // 3C+C4, id0, carry
    lit_exp[6]  = 10'h246;  // 12+34, id1
    lit_exp[7]  = 10'h100;
    lit_exp[8]  = 10'h246;
    lit_exp[9]  = 10'h100;
    lit_exp[10] = 10'h246;
    lit_exp[11] = 10'h234;  // 21+13, id1 after aborted add
    lit_exp[12] = 10'h033;  // latched 11+22, not EE+22
    lit_exp[13] = 10'h203;  // 01+02, id1
    for (int i = 0; i < N_RESULT; i++) lit_has[i] = 1'b1;

    tb_end   = 1'b0;
    cyc      = 0;
    n_tests  = 0;
    n_fail   = 0;
    m_ndone  = 0;
    dut_ndone = 0;
    rst_n    = 1'b0;
    bus.req0 = 1'b0;
    bus.a0   = 8'h00;
    bus.b0   = 8'h00;
    bus.req1 = 1'b0;
    bus.a1   = 8'h00;
    bus.b1   = 8'h00;
    step(3);
    rst_n = 1'b1;
    step(1);

    // Single requester 0
    bus.req0 = 1'b1; bus.a0 = 8'h0F; bus.b0 = 8'h01;
    step(1); bus.req0 = 1'b0;
    step(12);

    // Single requester 1, twice
    bus.req1 = 1'b1; bus.a1 = 8'hFF; bus.b1 = 8'h01;
    step(1); bus.req1 = 1'b0;
    step(12);
    bus.req1 = 1'b1; bus.a1 = 8'hA5; bus.b1 = 8'h5A;
    step(1); bus.req1 = 1'b0;
    step(12);

    // Simultaneous requests straight after reset: 0 wins, 1 waits
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
    bus.a0 = 8'h03; bus.b0 = 8'h04; bus.a1 = 8'h80; bus.b1 = 8'h80;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    step(1); bus.req0 = 1'b0;
    step(10); bus.req1 = 1'b0;
    step(12);

    // Both held for six transactions
    bus.a0 = 8'h3C; bus.b0 = 8'hC4; bus.a1 = 8'h12; bus.b1 = 8'h34;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    step(51);
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    step(12);

    // Reset in the fourth RUN cycle, then requester 1 alone
    bus.req0 = 1'b1; bus.a0 = 8'hFF; bus.b0 = 8'hFF;
    step(1); bus.req0 = 1'b0;
    step(3); rst_n = 1'b0;
    step(1); rst_n = 1'b1;
    bus.req1 = 1'b1; bus.a1 = 8'h21; bus.b1 = 8'h13;
    step(1); bus.req1 = 1'b0;
    step(12);

    // req1 during RUN waits; a0 change after grant is ignored
    bus.req0 = 1'b1; bus.a0 = 8'h11; bus.b0 = 8'h22;
    step(1); bus.req0 = 1'b0; bus.a0 = 8'hEE;
    step(2); bus.req1 = 1'b1; bus.a1 = 8'h01; bus.b1 = 8'h02;
    step(8); bus.req1 = 1'b0;
    step(14);

    tb_end = 1'b1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog");
  end

endmodule
